// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, control-word bit map and fetch words shared by the sequencer
package cpu_ctrl_pkg;

   localparam int CTRL_W = 13;

   typedef logic [CTRL_W-1:0] ctrl_word_t;

   // Control-word bit indices, HLT in the MSB down to J in the LSB
   localparam int B_J   = 0;
   localparam int B_CO  = 1;
   localparam int B_CE  = 2;
   localparam int B_OI  = 3;
   localparam int B_BI  = 4;
   localparam int B_AO  = 5;
   localparam int B_AI  = 6;
   localparam int B_II  = 7;
   localparam int B_IO  = 8;
   localparam int B_RO  = 9;
   localparam int B_RI  = 10;
   localparam int B_MI  = 11;
   localparam int B_HLT = 12;

   localparam ctrl_word_t C_J   = ctrl_word_t'(1) << B_J;
   localparam ctrl_word_t C_CO  = ctrl_word_t'(1) << B_CO;
   localparam ctrl_word_t C_CE  = ctrl_word_t'(1) << B_CE;
   localparam ctrl_word_t C_OI  = ctrl_word_t'(1) << B_OI;
   localparam ctrl_word_t C_BI  = ctrl_word_t'(1) << B_BI;
   localparam ctrl_word_t C_AO  = ctrl_word_t'(1) << B_AO;
   localparam ctrl_word_t C_AI  = ctrl_word_t'(1) << B_AI;
   localparam ctrl_word_t C_II  = ctrl_word_t'(1) << B_II;
   localparam ctrl_word_t C_IO  = ctrl_word_t'(1) << B_IO;
   localparam ctrl_word_t C_RO  = ctrl_word_t'(1) << B_RO;
   localparam ctrl_word_t C_RI  = ctrl_word_t'(1) << B_RI;
   localparam ctrl_word_t C_MI  = ctrl_word_t'(1) << B_MI;
   localparam ctrl_word_t C_HLT = ctrl_word_t'(1) << B_HLT;

   // Opcode-independent fetch micro-ops
   localparam ctrl_word_t FETCH_T0 = C_CO | C_MI;
   localparam ctrl_word_t FETCH_T1 = C_RO | C_II | C_CE;

   localparam int OP_NOP = 0;
   localparam int OP_LDA = 1;
   localparam int OP_ADD = 2;
   localparam int OP_SUB = 3;
   localparam int OP_STA = 4;
   localparam int OP_LDI = 5;
   localparam int OP_JMP = 6;
   localparam int OP_JC  = 7;
   localparam int OP_JZ  = 8;
   localparam int OP_OUT = 14;
   localparam int OP_HLT = 15;

   // One decoded micro-step: bus/register enables plus the ALU-side terms
   typedef struct packed {
      ctrl_word_t ctrl;
      logic       eo;
      logic       fi;
      logic       su;
   } uop_t;

endpackage

// File: rtl/step_counter.sv
// rtl/step_counter.sv - mod-STEPS T-state counter with async clear, hold and sync load-zero
module step_counter #(
   parameter int STEPS = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hold,
   input  logic       load_zero,
   output logic [2:0] step
);

   localparam logic [2:0] LAST = 3'(STEPS - 1);

   logic [2:0] step_d;
   logic [2:0] step_q;

   // Next step: hold wins (halt), then early restart or wrap, else count up
   always_comb begin
      step_d = step_q;
      if (hold) begin
         step_d = step_q;
      end else if (load_zero || (step_q == LAST)) begin
         step_d = '0;
      end else begin
         step_d = step_q + 3'd1;
      end
   end

   // Step register, cleared asynchronously so an instruction aborts at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q <= '0;
      end else begin
         step_q <= step_d;
      end
   end

   assign step = step_q;

endmodule

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - T-state sequencer and control-word decode (option: SEQ_EARLY_RESET_EN)
module microcode_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int STEPS = 5,
   parameter int OPW   = 4
) (
   input  logic              CLK,
   input  logic              CLR_n,
   input  logic [OPW-1:0]    OPCODE,
   input  logic              CF,
   input  logic              ZF,
   output logic [CTRL_W-1:0] CTRL,
   output logic              SU,
   output logic              EO_n,
   output logic              FI_n,
   output logic [2:0]        STEP,
   output logic              HALTED
);

   int   op;
   uop_t dec;
   logic halted_d;
   logic halted_q;
   logic hold;
   logic early_zero;

   assign op = int'(OPCODE);

   // Decode (STEP, OPCODE, flags) into one micro-step; steps 5 and up stay zero
   always_comb begin
      dec = '0;
      case (STEP)
         3'd0: dec.ctrl = FETCH_T0;
         3'd1: dec.ctrl = FETCH_T1;
         3'd2: begin
            case (op)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: dec.ctrl = C_IO | C_MI;
               OP_LDI: dec.ctrl = C_IO | C_AI;
               OP_JMP: dec.ctrl = C_IO | C_J;
               OP_JC:  dec.ctrl = CF ? (C_IO | C_J) : '0;
               OP_JZ:  dec.ctrl = ZF ? (C_IO | C_J) : '0;
               OP_OUT: dec.ctrl = C_AO | C_OI;
               OP_HLT: dec.ctrl = C_HLT;
               default: dec.ctrl = '0;
            endcase
         end
         3'd3: begin
            case (op)
               OP_LDA:         dec.ctrl = C_RO | C_AI;
               OP_ADD, OP_SUB: dec.ctrl = C_RO | C_BI;
               OP_STA:         dec.ctrl = C_AO | C_RI;
               default:        dec.ctrl = '0;
            endcase
         end
         3'd4: begin
            if (op == OP_ADD || op == OP_SUB) begin
               dec.ctrl = C_AI;
               dec.eo   = 1'b1;
               dec.fi   = 1'b1;
               dec.su   = (op == OP_SUB);
            end
         end
         default: dec = '0;
      endcase
   end

   // Once HLT is seen the counter must not leave the halting step
   assign hold     = halted_q | dec.ctrl[B_HLT];
   assign halted_d = halted_q | dec.ctrl[B_HLT];

`ifdef SEQ_EARLY_RESET_EN
   assign early_zero = (STEP >= 3'd2) && (dec == '0);
`else
   assign early_zero = 1'b0;
`endif

   step_counter #(
      .STEPS (STEPS)
   ) u_step_counter (
      .clk       (CLK),
      .rst_n     (CLR_n),
      .hold      (hold),
      .load_zero (early_zero),
      .step      (STEP)
   );

   // Sticky halt flag; only the asynchronous clear releases it
   always_ff @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end

   assign HALTED = halted_q;

   // Drive outputs: forced idle while clear is low, HLT-only while halted
   always_comb begin
      CTRL = '0;
      SU   = 1'b0;
      EO_n = 1'b1;
      FI_n = 1'b1;
      if (!CLR_n) begin
         CTRL = '0;
      end else if (halted_q) begin
         CTRL = C_HLT;
      end else begin
         CTRL = dec.ctrl;
         SU   = dec.su;
         EO_n = ~dec.eo;
         FI_n = ~dec.fi;
      end
   end

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - self-checking bench for microcode_sequencer (honours SEQ_EARLY_RESET_EN)
module tb_microcode_sequencer;

   localparam int STEPS = 5;

`ifdef SEQ_EARLY_RESET_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   localparam logic [12:0] K_HLT = 13'h1000;
   localparam logic [12:0] K_MI  = 13'h0800;
   localparam logic [12:0] K_RI  = 13'h0400;
   localparam logic [12:0] K_RO  = 13'h0200;
   localparam logic [12:0] K_IO  = 13'h0100;
   localparam logic [12:0] K_II  = 13'h0080;
   localparam logic [12:0] K_AI  = 13'h0040;
   localparam logic [12:0] K_AO  = 13'h0020;
   localparam logic [12:0] K_BI  = 13'h0010;
   localparam logic [12:0] K_OI  = 13'h0008;
   localparam logic [12:0] K_CE  = 13'h0004;
   localparam logic [12:0] K_CO  = 13'h0002;
   localparam logic [12:0] K_J   = 13'h0001;

   logic        CLK    = 1'b0;
   logic        CLR_n  = 1'b1;
   logic [3:0]  OPCODE = 4'd0;
   logic        CF     = 1'b0;
   logic        ZF     = 1'b0;
   logic [12:0] CTRL;
   logic        SU;
   logic        EO_n;
   logic        FI_n;
   logic [2:0]  STEP;
   logic        HALTED;

   int checks = 0;
   int errors = 0;

   // Reference model state and execute-step table [opcode][step]
   int          m_step   = 0;
   logic        m_halted = 1'b0;
   logic [12:0] t_ctrl [16][5];
   logic        t_eo   [16][5];
   logic        t_fi   [16][5];
   logic        t_su   [16][5];
   logic [15:0] exp_w;

   int seq_def   [6] = '{0, 1, 2, 3, 4, 0};
   int seq_early [6] = '{0, 1, 2, 3, 0, 1};

   microcode_sequencer dut (
      .CLK    (CLK),
      .CLR_n  (CLR_n),
      .OPCODE (OPCODE),
      .CF     (CF),
      .ZF     (ZF),
      .CTRL   (CTRL),
      .SU     (SU),
      .EO_n   (EO_n),
      .FI_n   (FI_n),
      .STEP   (STEP),
      .HALTED (HALTED)
   );

   always #5 CLK = ~CLK;

   // Expected {ctrl, su, eo_n, fi_n} from the instruction table
   function automatic logic [15:0] model_out(input int s, input int op, input logic cf,
                                             input logic zf, input logic rst, input logic hl);
      logic [12:0] c;
      logic        su;
      logic        eo;
      logic        fi;
      c  = 13'h0;
      su = 1'b0;
      eo = 1'b0;
      fi = 1'b0;
      if (!rst)            c = 13'h0;
      else if (hl)         c = K_HLT;
      else if (s == 0)     c = K_CO | K_MI;
      else if (s == 1)     c = K_RO | K_II | K_CE;
      else if (s >= 5)     c = 13'h0;
      else if (op == 7 && s == 2) c = cf ? (K_IO | K_J) : 13'h0;
      else if (op == 8 && s == 2) c = zf ? (K_IO | K_J) : 13'h0;
      else begin
         c  = t_ctrl[op][s];
         su = t_su[op][s];
         eo = t_eo[op][s];
         fi = t_fi[op][s];
      end
      return {c, su, ~eo, ~fi};
   endfunction

   assign exp_w = model_out(m_step, int'(OPCODE), CF, ZF, CLR_n, m_halted);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic restart();
      CLR_n = 1'b0;
      #1;
      CLR_n = 1'b1;
      #1;
   endtask

   // Model step/halt progression
   always @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) begin
         m_step   <= 0;
         m_halted <= 1'b0;
      end else if (!m_halted) begin
         if (model_out(m_step, int'(OPCODE), CF, ZF, 1'b1, 1'b0) & 16'h8000)
            m_halted <= 1'b1;
         else if (EARLY && m_step >= 2 &&
                  model_out(m_step, int'(OPCODE), CF, ZF, 1'b1, 1'b0) == 16'h0003)
            m_step <= 0;
         else
            m_step <= (m_step == STEPS - 1) ? 0 : m_step + 1;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge CLK) begin
      chk("cycle {ctrl,su,eo_n,fi_n,step,halted}",
          32'({CTRL, SU, EO_n, FI_n, STEP, HALTED}),
          32'({exp_w, 3'(m_step), m_halted}));
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      for (int o = 0; o < 16; o++) begin
         for (int s = 0; s < 5; s++) begin
            t_ctrl[o][s] = 13'h0;
            t_eo[o][s]   = 1'b0;
            t_fi[o][s]   = 1'b0;
            t_su[o][s]   = 1'b0;
         end
      end
      t_ctrl[1][2]  = K_IO | K_MI;  t_ctrl[1][3] = K_RO | K_AI;
      t_ctrl[2][2]  = K_IO | K_MI;  t_ctrl[2][3] = K_RO | K_BI;  t_ctrl[2][4] = K_AI;
      t_eo[2][4]    = 1'b1;         t_fi[2][4]   = 1'b1;
      t_ctrl[3][2]  = K_IO | K_MI;  t_ctrl[3][3] = K_RO | K_BI;  t_ctrl[3][4] = K_AI;
      t_eo[3][4]    = 1'b1;         t_fi[3][4]   = 1'b1;         t_su[3][4]   = 1'b1;
      t_ctrl[4][2]  = K_IO | K_MI;  t_ctrl[4][3] = K_AO | K_RI;
      t_ctrl[5][2]  = K_IO | K_AI;
      t_ctrl[6][2]  = K_IO | K_J;
      t_ctrl[14][2] = K_AO | K_OI;
      t_ctrl[15][2] = K_HLT;

      // Reset held across clock edges
      #1 CLR_n = 1'b0;
      repeat (3) cyc();
      #1;
      chk("rst_outputs {ctrl,su,eo_n,fi_n,step,halted}",
          32'({CTRL, SU, EO_n, FI_n, STEP, HALTED}), 32'({13'h0, 3'b011, 3'd0, 1'b0}));
      CLR_n = 1'b1;
      #1;
      chk("fetch_t0 ctrl", 32'(CTRL), 32'h0802);
      cyc();
      #1;
      chk("fetch_t1 ctrl", 32'(CTRL), 32'h0284);

      // SUB: ALU terms only on T4, then wrap
      cyc();
      OPCODE = 4'd3;
      restart();
      for (int s = 0; s < 5; s++) begin
         chk("sub step", 32'(STEP), 32'(s));
         if (s == 4)
            chk("sub_t4 {su,eo_n,fi_n,ctrl}", 32'({SU, EO_n, FI_n, CTRL}), 32'({3'b100, 13'h0040}));
         else
            chk("sub su_low", 32'(SU), 32'd0);
         cyc();
      end
      chk("sub wrap step", 32'(STEP), 32'd0);

      // JC without carry never jumps
      OPCODE = 4'd7;
      CF = 1'b0;
      restart();
      for (int s = 0; s < 5; s++) begin
         chk("jc_nocarry j", 32'(CTRL[0]), 32'd0);
         cyc();
      end

      // JC with carry jumps at T2
      CF = 1'b1;
      restart();
      cyc();
      cyc();
      chk("jc_carry_t2 ctrl", 32'(CTRL), 32'h0101);

      // JZ with zero; ZF toggled during T3 changes nothing
      CF = 1'b0;
      ZF = 1'b1;
      OPCODE = 4'd8;
      restart();
      cyc();
      cyc();
      chk("jz_t2 ctrl", 32'(CTRL), 32'h0101);
      cyc();
      ZF = 1'b0;
      #1;
      chk("jz_t3 {step,ctrl}", 32'({STEP, CTRL}), 32'({3'd3, 13'h0}));
      ZF = 1'b1;
      #1;
      chk("jz_t3_toggle ctrl", 32'(CTRL), 32'h0);
      cyc();
      chk("jz_after_t3 step", 32'(STEP), EARLY ? 32'd0 : 32'd4);

      // HLT freezes at T2 regardless of inputs
      OPCODE = 4'd15;
      ZF = 1'b0;
      restart();
      cyc();
      cyc();
      chk("hlt_t2 {halted,ctrl}", 32'({HALTED, CTRL}), 32'({1'b0, 13'h1000}));
      cyc();
      chk("hlt_set {halted,step}", 32'({HALTED, STEP}), 32'({1'b1, 3'd2}));
      for (int i = 0; i < 20; i++) begin
         OPCODE = 4'($urandom_range(0, 15));
         CF = 1'($urandom);
         ZF = 1'($urandom);
         #1;
         chk("halted {step,ctrl,su,eo_n,fi_n}", 32'({STEP, CTRL, SU, EO_n, FI_n}),
             32'({3'd2, 13'h1000, 3'b011}));
         cyc();
      end
      restart();
      chk("hlt_clear {halted,step,ctrl}", 32'({HALTED, STEP, CTRL}), 32'({1'b0, 3'd0, 13'h0802}));

      // Asynchronous abort during ADD T3
      cyc();
      OPCODE = 4'd2;
      CF = 1'b0;
      ZF = 1'b0;
      restart();
      cyc();
      cyc();
      cyc();
      chk("add_t3 ctrl", 32'(CTRL), 32'h0210);
      CLR_n = 1'b0;
      #1;
      chk("midrst {ctrl,su,eo_n,fi_n,step}", 32'({CTRL, SU, EO_n, FI_n, STEP}),
          32'({13'h0, 3'b011, 3'd0}));
      cyc();
      chk("midrst_held {ctrl,step,halted}", 32'({CTRL, STEP, HALTED}), 32'({13'h0, 3'd0, 1'b0}));
      CLR_n = 1'b1;
      #1;
      chk("midrst_release ctrl", 32'(CTRL), 32'h0802);

      // LDI step sequence, with and without early restart
      cyc();
      OPCODE = 4'd5;
      restart();
      for (int i = 0; i < 6; i++) begin
         chk("ldi step", 32'(STEP), EARLY ? 32'(seq_early[i]) : 32'(seq_def[i]));
         if (i == 2) chk("ldi_t2 ctrl", 32'(CTRL), 32'h0140);
         if (i == 3) chk("ldi_t3 ctrl", 32'(CTRL), 32'h0);
         cyc();
      end

      // Sweep every opcode with changing flags; the cycle compare does the work
      for (int o = 0; o < 16; o++) begin
         OPCODE = 4'(o);
         CF = 1'($urandom);
         ZF = 1'($urandom);
         restart();
         repeat (7) begin
            cyc();
            CF = 1'($urandom);
            ZF = 1'($urandom);
         end
      end

      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
